// File: rtl/stream_pkg.sv
// Shared stb/ack toolbox definitions: FSM state encodings and default width.
// Used by stream_fork and future join/merge blocks.
package stream_pkg;

    localparam int unsigned STREAM_BITS = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT   = 2'd0;
    localparam state_t ST_ACCEPT = 2'd1;
    localparam state_t ST_SEND   = 2'd2;

endpackage

// File: rtl/fork_skid_reg.sv
// One-entry data + valid holding register for stream_fork.
// Load has priority over clear; both act on the rising clock edge.
module fork_skid_reg
    import stream_pkg::*;
#(
    parameter int unsigned bits = STREAM_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [bits-1:0] data_i,
    output logic            valid_o,
    output logic [bits-1:0] data_o
);

    logic            valid_q, valid_d;
    logic [bits-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/stream_fork.sv
// Stream duplicator: one stb/ack producer feeds two independent consumers.
// Define FORK_SKID_EN to add a one-entry skid register for 1 word/cycle.
module stream_fork
    import stream_pkg::*;
#(
    parameter int unsigned bits = STREAM_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [bits-1:0] in1,
    input  logic            in1_stb,
    output logic            in1_ack,
    output logic [bits-1:0] out1,
    output logic            out1_stb,
    input  logic            out1_ack,
    output logic [bits-1:0] out2,
    output logic            out2_stb,
    input  logic            out2_ack
);

    state_t          state_q, state_d;
    logic [bits-1:0] data_q,  data_d;
    logic            s1_q,    s1_d;
    logic            s2_q,    s2_d;
    logic            ack_q,   ack_d;
    logic            in_xfer;
    logic            done;

`ifdef FORK_SKID_EN
    logic            skid_load;
    logic            skid_clr;
    logic            skid_vld;
    logic [bits-1:0] skid_data;

    fork_skid_reg #(
        .bits    (bits)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in1),
        .valid_o (skid_vld),
        .data_o  (skid_data)
    );
`endif

    assign in_xfer = in1_stb && ack_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        ack_d   = ack_q;
        done    = 1'b0;
`ifdef FORK_SKID_EN
        skid_load = 1'b0;
        skid_clr  = 1'b0;
`endif
        unique case (state_q)
            ST_INIT: begin
                ack_d   = 1'b1;
                state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (in_xfer) begin
                    data_d  = in1;
                    s1_d    = 1'b1;
                    s2_d    = 1'b1;
`ifdef FORK_SKID_EN
                    ack_d   = 1'b1;
`else
                    ack_d   = 1'b0;
`endif
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                s1_d = s1_q && !out1_ack;
                s2_d = s2_q && !out2_ack;
                done = !s1_d && !s2_d;
`ifdef FORK_SKID_EN
                // A pending skid word wins; otherwise a live input bypasses the skid.
                if (done) begin
                    ack_d = 1'b1;
                    if (skid_vld) begin
                        data_d   = skid_data;
                        s1_d     = 1'b1;
                        s2_d     = 1'b1;
                        skid_clr = 1'b1;
                    end else if (in_xfer) begin
                        data_d = in1;
                        s1_d   = 1'b1;
                        s2_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    ack_d     = 1'b0;
                end
`else
                if (done) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACCEPT;
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
                ack_d   = 1'b0;
                s1_d    = 1'b0;
                s2_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            data_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            ack_q   <= ack_d;
        end
    end

    assign in1_ack  = ack_q;
    assign out1     = data_q;
    assign out2     = data_q;
    assign out1_stb = s1_q;
    assign out2_stb = s2_q;

endmodule

// File: tb/tb_stream_fork.sv
// Scoreboard bench for stream_fork; expected-throughput figure follows FORK_SKID_EN.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_stream_fork;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in1;
    logic        in1_stb;
    logic        in1_ack;
    logic [15:0] out1;
    logic        out1_stb;
    logic        out1_ack;
    logic [15:0] out2;
    logic        out2_stb;
    logic        out2_ack;

    stream_fork #(.bits(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in1      (in1),
        .in1_stb  (in1_stb),
        .in1_ack  (in1_ack),
        .out1     (out1),
        .out1_stb (out1_stb),
        .out1_ack (out1_ack),
        .out2     (out2),
        .out2_stb (out2_stb),
        .out2_ack (out2_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_in;
    int last_out;
    int n1;
    int n2;
    bit rand_ack = 1'b0;
    logic [15:0] exp1[$];
    logic [15:0] exp2[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: stb && ack at the falling edge means a transfer on the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out1_stb && exp1.size() == 0)
                check("spurious_out1_stb", 32'(out1_stb), 32'd0);
            else if (out1_stb && out1_ack) begin
                check("out1_data", 32'(out1), 32'(exp1.pop_front()));
                n1 = n1 + 1;
                last_out = cyc;
            end
            if (out2_stb && exp2.size() == 0)
                check("spurious_out2_stb", 32'(out2_stb), 32'd0);
            else if (out2_stb && out2_ack) begin
                check("out2_data", 32'(out2), 32'(exp2.pop_front()));
                n2 = n2 + 1;
                last_out = cyc;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ack) begin
            out1_ack = 1'($urandom_range(0, 1));
            out2_ack = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bit hs;
        int k;
        exp1.push_back(w);
        exp2.push_back(w);
        in1     = w;
        in1_stb = 1'b1;
        k  = 0;
        hs = 1'b0;
        while (!hs && k < 1000) begin
            @(negedge clk);
            hs = in1_ack;
            if (hs && first_in < 0) first_in = cyc;
            tick();
            k = k + 1;
        end
        if (!hs) check("send_timeout", 32'd0, 32'd1);
        in1_stb = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp1.size() != 0 || exp2.size() != 0) && k < 3000) begin
            tick();
            k = k + 1;
        end
        check("drain_q1", 32'(exp1.size()), 32'd0);
        check("drain_q2", 32'(exp2.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in1      = '0;
        in1_stb  = 1'b0;
        out1_ack = 1'b0;
        out2_ack = 1'b0;
        first_in = -1;
        last_out = 0;
        n1 = 0;
        n2 = 0;

        // Reset state, then reset asserted mid-SEND
        tick();
        tick();
        check("rst_in1_ack", 32'(in1_ack), 32'd0);
        check("rst_out1_stb", 32'(out1_stb), 32'd0);
        check("rst_out2_stb", 32'(out2_stb), 32'd0);
        check("rst_out1", 32'(out1), 32'd0);
        rst_n = 1'b1;
        tick();
        check("init_ack", 32'(in1_ack), 32'd1);
        exp1.push_back(16'hABCD);
        exp2.push_back(16'hABCD);
        in1     = 16'hABCD;
        in1_stb = 1'b1;
        tick();
        in1_stb = 1'b0;
        check("send_out1_stb", 32'(out1_stb), 32'd1);
        check("send_out1", 32'(out1), 32'hABCD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out1_stb", 32'(out1_stb), 32'd0);
        check("async_out2_stb", 32'(out2_stb), 32'd0);
        check("async_out1", 32'(out1), 32'd0);
        check("async_out2", 32'(out2), 32'd0);
        check("async_in1_ack", 32'(in1_ack), 32'd0);
        exp1.delete();
        exp2.delete();
        tick();
        rst_n = 1'b1;
        check("rel_in1_ack", 32'(in1_ack), 32'd0);
        tick();
        check("rel_in1_ack_edge", 32'(in1_ack), 32'd1);

        // Basic transfer with both consumers acking
        out1_ack = 1'b1;
        out2_ack = 1'b1;
        send(16'h1234);
        check("basic_stb1", 32'(out1_stb), 32'd1);
        check("basic_stb2", 32'(out2_stb), 32'd1);
        check("basic_out1", 32'(out1), 32'h1234);
        check("basic_out2", 32'(out2), 32'h1234);
`ifndef FORK_SKID_EN
        check("basic_ack_low", 32'(in1_ack), 32'd0);
`endif
        tick();
        check("basic_stb1_drop", 32'(out1_stb), 32'd0);
        check("basic_stb2_drop", 32'(out2_stb), 32'd0);
        check("basic_ack_back", 32'(in1_ack), 32'd1);

        // Skewed consumers: out2 stalls for 5 cycles
        out2_ack = 1'b0;
        send(16'h5A5A);
        check("skew_stb2", 32'(out2_stb), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("skew_stb1_low", 32'(out1_stb), 32'd0);
            check("skew_stb2_high", 32'(out2_stb), 32'd1);
            check("skew_out1_hold", 32'(out1), 32'h5A5A);
            check("skew_out2_hold", 32'(out2), 32'h5A5A);
`ifndef FORK_SKID_EN
            check("skew_ack_low", 32'(in1_ack), 32'd0);
`endif
        end
        out2_ack = 1'b1;
        tick();
        check("skew_stb2_drop", 32'(out2_stb), 32'd0);
        check("skew_ack_back", 32'(in1_ack), 32'd1);

        // Producer stalls with extreme data
        send(16'hFFFF);
        repeat (3) tick();
        send(16'h0000);
        repeat (2) tick();
        send(16'h8001);
        drain();

        // Sequence 0..99 with random acks
        rand_ack = 1'b1;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'(i));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_ack = 1'b0;
        tick();
        check("seq_n1", 32'(n1), 32'd100);
        check("seq_n2", 32'(n2), 32'd100);

        // Throughput with everything always ready
        out1_ack = 1'b1;
        out2_ack = 1'b1;
        tick();
        first_in = -1;
        last_out = 0;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 100; i++) send(16'(16'h0100 + i));
        drain();
        check("thru_n1", 32'(n1), 32'd100);
        check("thru_n2", 32'(n2), 32'd100);
`ifdef FORK_SKID_EN
        check("thru_cycles", 32'(last_out - first_in + 1), 32'd101);
`else
        check("thru_cycles", 32'(last_out - first_in + 1), 32'd200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
